// File: rtl/dtw_mem_pkg.sv
// Shared definitions for the DTW template memory: burst FSM encoding,
// read-latency bounds and byte-lane helpers.
package dtw_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } burst_state_e;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;
    localparam int unsigned BYTE_W     = 8;

    // Number of byte lanes in a data word.
    function automatic int unsigned lane_count(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/dtw_mem_rd_pipe.sv
// Read-result delay line: STAGES-deep shift of {valid, data}.
// Ports:
//   clk, rst            clock, synchronous active-high flush
//   src_valid/src_data  result entering stage 0 (data zeroed when not valid)
//   dst_valid/dst_data  registered output of the last stage
//   nxt_valid_c/nxt_data_c  value that loads into the last stage at the next edge
module dtw_mem_rd_pipe #(
    parameter int unsigned W      = 33,
    parameter int unsigned STAGES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         src_valid,
    input  logic [W-1:0] src_data,
    output logic         dst_valid,
    output logic [W-1:0] dst_data,
    output logic         nxt_valid_c,
    output logic [W-1:0] nxt_data_c
);

    logic [STAGES-1:0] vld;
    logic [W-1:0]      dat [STAGES];
    logic [W-1:0]      src_masked_c;

    // Idle slots carry zero so the output data is never stale.
    assign src_masked_c = src_valid ? src_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                dat[k] <= '0;
            end
        end else begin
            vld[0] <= src_valid;
            dat[0] <= src_masked_c;
            for (int k = 1; k < int'(STAGES); k++) begin
                vld[k] <= vld[k-1];
                dat[k] <= dat[k-1];
            end
        end
    end

    assign dst_valid = vld[STAGES-1];
    assign dst_data  = dat[STAGES-1];

    // Look-ahead into the output stage, used to align strobes with the output.
    generate
        if (STAGES == 1) begin : g_tap_src
            assign nxt_valid_c = src_valid;
            assign nxt_data_c  = src_masked_c;
        end else begin : g_tap_stage
            assign nxt_valid_c = vld[STAGES-2];
            assign nxt_data_c  = dat[STAGES-2];
        end
    endgenerate

endmodule

// File: rtl/dtw_template_mem.sv
// Single-port template memory with byte-enable writes, pipelined reads and
// an autonomous burst-read engine that has priority over direct accesses.
// Optional macro MEM_TRISTATE_EN adds io_dbus, a shared-bus copy of o_rdata
// driven only while o_rvalid is high.
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_cs_n, i_wr, i_addr, i_wdata, i_be  direct access (active-low select)
//   o_rdata, o_rvalid                  read result and its valid strobe
//   i_burst_start/base/len             burst request
//   o_burst_busy, o_burst_done         burst status
//   o_err                              pulse for a dropped direct access
module dtw_template_mem
    import dtw_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned LEN_W     = 6,
    parameter string       INIT_FILE = "data/memory.vec"
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cs_n,
    input  logic                       i_wr,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [DATA_W/BYTE_W-1:0]   i_be,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_rvalid,
    input  logic                       i_burst_start,
    input  logic [ADDR_W-1:0]          i_burst_base,
    input  logic [LEN_W-1:0]           i_burst_len,
    output logic                       o_burst_busy,
    output logic                       o_burst_done,
    output logic                       o_err
`ifdef MEM_TRISTATE_EN
    ,
    inout  wire  [DATA_W-1:0]          io_dbus
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned NB    = lane_count(DATA_W);
    localparam int unsigned PW    = DATA_W + 1;
    localparam int unsigned LAT   = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                    (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    logic [DATA_W-1:0] mem [DEPTH];

    burst_state_e      state, state_nxt;
    logic [ADDR_W-1:0] b_addr, b_addr_nxt;
    logic [LEN_W-1:0]  b_left, b_left_nxt;
    logic              zero_done_c;
    logic              busy_q, done_q, err_q;

    logic              accept_c, busy_c, drop_c;
    logic              wr_en_c, rd_dir_c, burst_rd_c, last_c, rd_en_c;
    logic [ADDR_W-1:0] rd_addr_c;

    // Arbitration: the burst engine owns the port from acceptance until done.
    assign accept_c   = (state == ST_IDLE) && i_burst_start;
    assign busy_c     = (state != ST_IDLE);
    assign drop_c     = !i_cs_n && (accept_c || busy_c);
    assign wr_en_c    = !i_cs_n && i_wr && !drop_c && !i_rst;
    assign rd_dir_c   = !i_cs_n && !i_wr && !drop_c;
    assign burst_rd_c = (state == ST_RUN);
    assign last_c     = burst_rd_c && (b_left == LEN_W'(1));
    assign rd_en_c    = rd_dir_c || burst_rd_c;
    assign rd_addr_c  = burst_rd_c ? b_addr : i_addr;

    // Burst FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            b_addr <= '0;
            b_left <= '0;
        end else begin
            state  <= state_nxt;
            b_addr <= b_addr_nxt;
            b_left <= b_left_nxt;
        end
    end

    // Burst FSM next state; DRAIN ends in the cycle the last word is presented.
    always_comb begin
        state_nxt   = state;
        b_addr_nxt  = b_addr;
        b_left_nxt  = b_left;
        zero_done_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_burst_start) begin
                    if (i_burst_len == '0) begin
                        zero_done_c = 1'b1;
                    end else begin
                        state_nxt  = ST_RUN;
                        b_addr_nxt = i_burst_base;
                        b_left_nxt = i_burst_len;
                    end
                end
            end
            ST_RUN: begin
                b_addr_nxt = b_addr + ADDR_W'(1);
                b_left_nxt = b_left - LEN_W'(1);
                if (b_left == LEN_W'(1)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (done_q) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Byte-lane write port.
    always_ff @(posedge i_clk) begin
        if (wr_en_c) begin
            for (int k = 0; k < int'(NB); k++) begin
                if (i_be[k]) mem[i_addr][k*BYTE_W +: BYTE_W] <= i_wdata[k*BYTE_W +: BYTE_W];
            end
        end
    end

    logic              pipe_valid, pipe_nxt_valid;
    logic [PW-1:0]     pipe_data, pipe_nxt_data;

    // Read results travel with a last-of-burst tag in the top bit.
    dtw_mem_rd_pipe #(
        .W      (PW),
        .STAGES (LAT)
    ) u_rd_pipe (
        .clk         (i_clk),
        .rst         (i_rst),
        .src_valid   (rd_en_c),
        .src_data    ({last_c, mem[rd_addr_c]}),
        .dst_valid   (pipe_valid),
        .dst_data    (pipe_data),
        .nxt_valid_c (pipe_nxt_valid),
        .nxt_data_c  (pipe_nxt_data)
    );

    // Status strobes, registered so done lines up with the last o_rvalid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= (state_nxt != ST_IDLE);
            done_q <= zero_done_c || (pipe_nxt_valid && pipe_nxt_data[DATA_W]);
            err_q  <= drop_c;
        end
    end

    assign o_rvalid     = pipe_valid;
    assign o_rdata      = pipe_data[DATA_W-1:0];
    assign o_burst_busy = busy_q;
    assign o_burst_done = done_q;
    assign o_err        = err_q;

    logic unused_bits_c;
    assign unused_bits_c = ^{pipe_data[DATA_W], pipe_nxt_data[DATA_W-1:0]};

`ifdef MEM_TRISTATE_EN
    // Shared-bus copy of the read result.
    assign io_dbus = o_rvalid ? o_rdata : {DATA_W{1'bz}};
`else
    // No shared-bus driver in this build.
`endif

endmodule

// File: tb/tb_dtw_template_mem.sv
// Bench for dtw_template_mem: two instances (read latency 1 and 3) share one
// stimulus stream; a cycle-indexed reference model predicts every output.
module tb_dtw_template_mem;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = 6;
    localparam int          DEPTH  = 1024;
    localparam int          MAXC   = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, cs_n, wr, bstart;
    logic [ADDR_W-1:0] addr, bbase;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic [LEN_W-1:0]  blen;

    logic [DATA_W-1:0] rdata1, rdata3;
    logic rvalid1, rvalid3, busy1, busy3, done1, done3, err1, err3;
`ifdef MEM_TRISTATE_EN
    wire  [DATA_W-1:0] dbus1, dbus3;
`endif

    dtw_template_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1), .LEN_W(LEN_W), .INIT_FILE("")) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_cs_n(cs_n), .i_wr(wr), .i_addr(addr), .i_wdata(wdata), .i_be(be),
        .o_rdata(rdata1), .o_rvalid(rvalid1), .i_burst_start(bstart), .i_burst_base(bbase),
        .i_burst_len(blen), .o_burst_busy(busy1), .o_burst_done(done1), .o_err(err1)
`ifdef MEM_TRISTATE_EN
        , .io_dbus(dbus1)
`endif
    );

    dtw_template_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(3), .LEN_W(LEN_W), .INIT_FILE("")) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_cs_n(cs_n), .i_wr(wr), .i_addr(addr), .i_wdata(wdata), .i_be(be),
        .o_rdata(rdata3), .o_rvalid(rvalid3), .i_burst_start(bstart), .i_burst_base(bbase),
        .i_burst_len(blen), .o_burst_busy(busy3), .o_burst_done(done3), .o_err(err3)
`ifdef MEM_TRISTATE_EN
        , .io_dbus(dbus3)
`endif
    );

    // Reference model: memory image per instance plus per-cycle expected outputs.
    logic [DATA_W-1:0] mmem  [2][DEPTH];
    bit                ev_v  [2][MAXC];
    logic [DATA_W-1:0] ev_d  [2][MAXC];
    bit                ev_done [2][MAXC];
    bit                ev_err  [2][MAXC];
    bit                ev_busy [2][MAXC];
    int                lat [2] = '{1, 3};
    bit                m_active [2];
    int                m_addr [2], m_left [2], m_end [2];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Apply the inputs sampled at edge e to both model instances.
    task automatic model_edge(input int e);
        bit busy_now, accept;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_active[i] = 1'b0;
                m_left[i]   = 0;
                for (int c = e; c < e + 4; c++) begin
                    ev_v[i][c] = 1'b0; ev_done[i][c] = 1'b0; ev_err[i][c] = 1'b0;
                end
                ev_busy[i][e] = 1'b0;
                continue;
            end
            busy_now = m_active[i];
            accept   = !busy_now && bstart;
            if (!cs_n) begin
                if (accept || busy_now) begin
                    ev_err[i][e] = 1'b1;
                end else if (wr) begin
                    for (int k = 0; k < 4; k++)
                        if (be[k]) mmem[i][addr][8*k +: 8] = wdata[8*k +: 8];
                end else begin
                    ev_v[i][e + lat[i] - 1] = 1'b1;
                    ev_d[i][e + lat[i] - 1] = mmem[i][addr];
                end
            end
            if (busy_now && m_left[i] > 0) begin
                ev_v[i][e + lat[i] - 1] = 1'b1;
                ev_d[i][e + lat[i] - 1] = mmem[i][m_addr[i]];
                m_addr[i] = (m_addr[i] + 1) % DEPTH;
                m_left[i]--;
                if (m_left[i] == 0) begin
                    ev_done[i][e + lat[i] - 1] = 1'b1;
                    m_end[i] = e + lat[i] - 1;
                end
            end else if (busy_now && e > m_end[i]) begin
                m_active[i] = 1'b0;
            end
            if (accept) begin
                if (blen == '0) begin
                    ev_done[i][e] = 1'b1;
                end else begin
                    m_active[i] = 1'b1;
                    m_addr[i]   = int'(bbase);
                    m_left[i]   = int'(blen);
                    m_end[i]    = 2 * MAXC;
                end
            end
            ev_busy[i][e] = m_active[i];
        end
    endtask

    task automatic check_dut(input int i, input logic rv, input logic [DATA_W-1:0] rd,
                             input logic dn, input logic er, input logic bz);
        logic [DATA_W-1:0] exp_d;
        exp_d = ev_v[i][cyc] ? ev_d[i][cyc] : '0;
        chk($sformatf("rvalid_lat%0d", lat[i]), 32'(rv), 32'(ev_v[i][cyc]));
        chk($sformatf("rdata_lat%0d", lat[i]),  rd, exp_d);
        chk($sformatf("done_lat%0d", lat[i]),   32'(dn), 32'(ev_done[i][cyc]));
        chk($sformatf("err_lat%0d", lat[i]),    32'(er), 32'(ev_err[i][cyc]));
        chk($sformatf("busy_lat%0d", lat[i]),   32'(bz), 32'(ev_busy[i][cyc]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(cyc);
        @(negedge clk);
        check_dut(0, rvalid1, rdata1, done1, err1, busy1);
        check_dut(1, rvalid3, rdata3, done3, err3, busy3);
`ifdef MEM_TRISTATE_EN
        n_checks++;
        assert (dbus1 === (rvalid1 ? rdata1 : {DATA_W{1'bz}})) else begin
            n_errors++;
            $error("FAIL dbus_lat1 cycle=%0d observed=%h expected=%h", cyc, dbus1, rdata1);
        end
        n_checks++;
        assert (dbus3 === (rvalid3 ? rdata3 : {DATA_W{1'bz}})) else begin
            n_errors++;
            $error("FAIL dbus_lat3 cycle=%0d observed=%h expected=%h", cyc, dbus3, rdata3);
        end
`endif
        cyc++;
    endtask

    task automatic idle_in();
        cs_n = 1'b1; wr = 1'b0; addr = '0; wdata = '0; be = '0;
        bstart = 1'b0; bbase = '0; blen = '0;
    endtask

    task automatic idle(input int n);
        idle_in();
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        rst = 1'b0;

        // Preload the whole array with known words.
        for (int a = 0; a < DEPTH; a++) begin
            cs_n = 1'b0; wr = 1'b1; be = 4'hF; addr = ADDR_W'(a);
            wdata = (a == 'h10) ? 32'h1122_3344 : $urandom;
            tick();
        end
        idle(2);

        // Back-to-back direct reads of words 0..3.
        for (int a = 0; a < 4; a++) begin
            cs_n = 1'b0; wr = 1'b0; addr = ADDR_W'(a);
            tick();
        end
        idle(4);

        // Partial-lane write, then read back.
        cs_n = 1'b0; wr = 1'b1; addr = 10'h010; wdata = 32'hDEAD_BEEF; be = 4'b0101;
        tick();
        cs_n = 1'b0; wr = 1'b0; addr = 10'h010; be = 4'b0000;
        tick();
        chk("be_merge_lat1", rdata1, 32'h11AD_33EF);
        idle(2);
        chk("be_merge_lat3", rdata3, 32'h11AD_33EF);
        idle(2);

        // Zero byte-enable write is a no-op.
        cs_n = 1'b0; wr = 1'b1; addr = 10'h011; wdata = $urandom; be = 4'b0000;
        tick();
        cs_n = 1'b0; wr = 1'b0; addr = 10'h011;
        tick();
        idle(4);

        // Wrapping burst with a direct write arriving while it runs.
        bstart = 1'b1; bbase = 10'h3FE; blen = 6'd4;
        tick();
        idle_in();
        cs_n = 1'b0; wr = 1'b1; addr = 10'h005; wdata = 32'hCAFE_F00D; be = 4'hF;
        tick();
        idle(10);
        cs_n = 1'b0; wr = 1'b0; addr = 10'h005;
        tick();
        idle(4);

        // Second start while busy is ignored.
        bstart = 1'b1; bbase = 10'h100; blen = 6'd4;
        tick();
        bstart = 1'b1; bbase = 10'h200; blen = 6'd2;
        tick();
        idle(10);

        // Zero-length burst with a colliding direct read.
        bstart = 1'b1; bbase = 10'h040; blen = 6'd0;
        cs_n = 1'b0; wr = 1'b0; addr = 10'h001;
        tick();
        idle(4);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom % 150) == 0;
            cs_n   = 1'($urandom_range(0, 1));
            wr     = 1'($urandom_range(0, 1));
            addr   = ADDR_W'($urandom);
            wdata  = $urandom;
            be     = 4'($urandom);
            bstart = ($urandom % 12) == 0;
            bbase  = ADDR_W'($urandom);
            blen   = LEN_W'($urandom_range(0, 10));
            tick();
        end
        rst = 1'b0;
        idle(12);

        // Reset in the middle of a long burst.
        bstart = 1'b1; bbase = 10'h020; blen = 6'd8;
        tick();
        idle(3);
        rst = 1'b1;
        tick();
        chk("rst_busy_lat3", 32'(busy3), 32'h0);
        rst = 1'b0;
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
